// File: rtl/axi_fifo_pkg.sv
// Shared width helpers and defaults for the AXI-style synchronous FIFO.
// Imported by axi_fifo_ptr and axi_sync_fifo.
package axi_fifo_pkg;

  localparam int AXI_FIFO_DEF_DEPTH = 32;
  localparam int AXI_FIFO_DEF_WIDTH = 32;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [cnt_w(AXI_FIFO_DEF_DEPTH)-1:0] def_count_t;

endpackage

// File: rtl/axi_fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
// Wraps naturally at 2**W, so the FIFO depth must be a power of two.
module axi_fifo_ptr
  import axi_fifo_pkg::*;
#(
  parameter int W = ptr_w(AXI_FIFO_DEF_DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/axi_sync_fifo.sv
// Single-clock FWFT FIFO with valid/ready on both sides and occupancy flags.
// Optional synchronous flush port when AXI_SYNC_FIFO_FLUSH_EN is defined.
module axi_sync_fifo
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = AXI_FIFO_DEF_WIDTH,
  parameter int DEPTH         = AXI_FIFO_DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [DATA_WIDTH-1:0]    i_s_data,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [DATA_WIDTH-1:0]    o_m_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty
`ifdef AXI_SYNC_FIFO_FLUSH_EN
  ,
  input  logic                     i_flush
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  typedef logic [CW-1:0] count_t;

  localparam count_t L_FULL   = count_t'(DEPTH);
  localparam count_t L_AFULL  = count_t'(AFULL_THRESH);
  localparam count_t L_AEMPTY = count_t'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  count_t                r_count;
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_clr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;

`ifdef AXI_SYNC_FIFO_FLUSH_EN
  assign w_clr = ~i_rst_n | i_flush;
`else
  assign w_clr = ~i_rst_n;
`endif

  // Ready depends only on registered state: no write-through when full.
  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = i_s_valid & ~w_full;
  assign w_pop   = i_m_ready & ~w_empty;

  axi_fifo_ptr #(.W(PW)) u_wr_ptr (
    .i_clk (i_clk),
    .i_clr (w_clr),
    .i_en  (w_push),
    .o_ptr (w_wr_ptr)
  );

  axi_fifo_ptr #(.W(PW)) u_rd_ptr (
    .i_clk (i_clk),
    .i_clr (w_clr),
    .i_en  (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge i_clk) begin
    if (w_push && !w_clr) begin
      r_mem[w_wr_ptr] <= i_s_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_count <= '0;
    end else begin
      unique case (1'b1)
        w_push & ~w_pop: r_count <= r_count + 1'b1;
        ~w_push & w_pop: r_count <= r_count - 1'b1;
        default:         r_count <= r_count;
      endcase
    end
  end

  assign o_s_ready      = ~w_full;
  assign o_m_valid      = ~w_empty;
  assign o_m_data       = w_empty ? '0 : r_mem[w_rd_ptr];
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= L_AFULL);
  assign o_almost_empty = (r_count <= L_AEMPTY);

endmodule

// File: doc/axi_sync_fifo.md
Name: axi_sync_fifo

Overview:
Parametrised single-clock FIFO; the successor to the fixed 32x32 FIFO top.
- Valid/ready handshakes on both sides, replacing raw wr_en/rd_en strobes.
- Full/empty back-pressure, occupancy count and programmable almost-full/almost-empty flags.
- First-word-fall-through output.
- Sits between AXI DMA channel front-ends and the burst engines.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 32, number of entries; power of two, >=2.
- AFULL_THRESH, DEPTH-4, o_almost_full asserts when count >= this value.
- AEMPTY_THRESH, 4, o_almost_empty asserts when count <= this value.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_s_valid  in  1  write side: data valid.
- o_s_ready  out  1  write side: FIFO can accept.
- i_s_data  in  DATA_WIDTH  write payload.
- o_m_valid  out  1  read side: data available.
- i_m_ready  in  1  read side: consumer accepts.
- o_m_data  out  DATA_WIDTH  read payload.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AFULL_THRESH.
- o_almost_empty  out  1  count <= AEMPTY_THRESH.

Behaviour:
- Reset is synchronous, active-low and sampled on i_clk.
  - While reset is low at an edge: wr_ptr, rd_ptr and count clear to 0.
  - Memory contents are not reset.
  - After that edge: o_s_ready=1, o_m_valid=0, o_m_data=0, o_count=0, o_full=0, o_empty=1, o_almost_full=0, o_almost_empty=1.
- Reset mid-operation discards all contents. Any push or pop in the reset cycle is ignored.
- push = i_s_valid & o_s_ready. pop = o_m_valid & i_m_ready.
- o_s_ready = !o_full.
  - No write pass-through when full: a push is refused in a full cycle even if a pop occurs in the same cycle.
  - This keeps ready free of combinational paths from i_m_ready.
- o_m_valid = !o_empty.
- FWFT read side:
  - o_m_data = mem[rd_ptr] while o_m_valid=1; o_m_data = 0 while o_m_valid=0.
  - Data must be held stable until popped.
- Latency: a push at edge N gives o_m_valid=1 and data visible after edge N, i.e. in cycle N+1.
  - No same-cycle bypass while empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Simultaneous push and pop is legal for any count in 1..DEPTH-1.
- Illegal valid/ready usage cannot over- or underflow:
  - i_s_valid while full is ignored.
  - i_m_ready while empty is ignored.
- All flags derive combinationally from the registered count, so they change in the cycle after the causing edge.
- Ordering is strictly FIFO; no data is lost or duplicated across wrap.

Optional Feature:
- Macro: AXI_SYNC_FIFO_FLUSH_EN.
- Defined:
  - Adds input port i_flush (1 bit).
  - i_flush=1 at an edge clears pointers and count exactly like reset.
  - Any simultaneous push or pop is discarded.
  - Flags read as empty from the next cycle.
  - i_rst_n has priority over i_flush.
- Undefined: the port is absent, with no flush logic.

Decomposition:
- Package axi_fifo_pkg holds:
  - function clog2-based width helpers;
  - typedef for the count type, parametrised via localparam in the module;
  - default constants AXI_FIFO_DEF_DEPTH=32 and AXI_FIFO_DEF_WIDTH=32.
- Sub-module axi_fifo_ptr: a wrapping pointer register with enable and synchronous clear (reset/flush).
  - Instantiated twice, for write and read.
- Memory array and count/flag logic live in the top.

Test Plan:
- Reset then idle, DEPTH=32: o_empty=1, o_s_ready=1, o_m_valid=0, o_count=0, o_m_data=0, o_almost_empty=1.
- Push 0x00000001..0x00000020 with i_m_ready=0:
  - o_full=1 and o_s_ready=0 after the 32nd push.
  - o_almost_full rises when count=28.
  - A 33rd valid is held and never accepted.
- Drain the full FIFO with i_m_ready=1: data returns 0x1..0x20 in order; o_empty=1 after the last pop; o_almost_empty rises at count=4.
- Continuous push+pop at count=5 for 100 cycles, with data crossing pointer wrap: o_count stays 5 and ordering is preserved.
- Single push 0xDEADBEEF into an empty FIFO: o_m_valid=1 on the following cycle with o_m_data=0xDEADBEEF, not in the same cycle.
- Assert i_rst_n=0 for one edge with 10 entries and push+pop active: count returns to 0 and the next pushed word 0xA5A5A5A5 is the first read. Repeat with i_flush when AXI_SYNC_FIFO_FLUSH_EN is defined.
